// File: rtl/ctrl_pkg.sv
// Shared state encoding, ALU op codes, opcodes and error causes for the
// multicycle controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExecR    = 4'd3,
    StExecI    = 4'd4,
    StAddrCalc = 4'd5,
    StMemLoad  = 4'd6,
    StWbLoad   = 4'd7,
    StMemStore = 4'd8,
    StWbAlu    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StError    = 4'd12
  } state_e;

  localparam logic [2:0] AluAdd = 3'b001;
  localparam logic [2:0] AluSub = 3'b010;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  // States that wait on mem_ready and are therefore covered by the timer.
  function automatic logic is_wait_state(input state_e s);
    return s inside {StFetch, StMemLoad, StMemStore};
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive memory-wait cycles; expired flags the cycle on which the
// count would reach the limit.
module ctrl_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && count_q != 8'hff) begin
      count_q <= count_q + 8'd1;
    end
  end

  // count_q holds the wait cycles already spent, so this cycle is number count_q + 1.
  assign expired = enable && (count_q >= limit - 8'd1);

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle RISC-style control unit: Moore FSM driving datapath enables and
// selects, with a memory-wait watchdog and a retired-instruction counter.
module ctrl_multicycle #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             load_a,
  output logic             load_b,
  output logic             load_alu_out,
  output logic             load_mdr,
  output logic             reg_write,
  output logic [2:0]       alu_op,
  output logic             sel_alu_a,
  output logic [1:0]       sel_alu_b,
  output logic             sel_pc,
  output logic [1:0]       sel_wb,
  output logic [3:0]       state_out,
  output logic             err,
  output logic [1:0]       err_cause,
  output logic [CNT_W-1:0] instret
);
  import ctrl_pkg::*;

  localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic             err_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             timeout, waiting, retire, r_legal, br_legal;
  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic             unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign r_legal  = (funct3 == 3'b000) && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
  assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign waiting  = is_wait_state(state_q) && !mem_ready;

  ctrl_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (waiting),
    .clear   (state_d != state_q),
    .limit   (TimeoutLimit),
    .expired (timeout)
  );

  always_comb begin
    state_d = state_q;
    cause_d = ErrNone;
    case (state_q)
      StReset:    state_d = StFetch;
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpR:             state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpLoad, OpStore: state_d = StAddrCalc;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = EN_JAL ? StJal : StError;
          default:         state_d = StError;
        endcase
        if (state_d == StError) cause_d = ErrIllegal;
      end
      StExecR: begin
        state_d = r_legal ? StWbAlu : StError;
        if (!r_legal) cause_d = ErrIllegal;
      end
      StExecI:    state_d = StWbAlu;
      StAddrCalc: state_d = (opcode == OpStore) ? StMemStore : StMemLoad;
      StMemLoad:  if (mem_ready) state_d = StWbLoad;
      StWbLoad:   state_d = StFetch;
      StMemStore: if (mem_ready) state_d = StFetch;
      StWbAlu:    state_d = StFetch;
      StBranch: begin
        state_d = br_legal ? StFetch : StError;
        if (!br_legal) cause_d = ErrIllegal;
      end
      StJal:      state_d = StFetch;
      StError:    state_d = StError;
      default:    state_d = StReset;
    endcase
    // Only raised while mem_ready is low, so a same-cycle ready always advances.
    if (timeout) begin
      state_d = StError;
      cause_d = ErrTimeout;
    end
  end

  assign retire = (state_d == StFetch) &&
                  (state_q inside {StWbAlu, StWbLoad, StMemStore, StBranch, StJal});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReset;
      err_q     <= 1'b0;
      cause_q   <= ErrNone;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StError && !err_q) begin
        err_q   <= 1'b1;
        cause_q <= cause_d;
      end
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_alu_out = 1'b0;
    load_mdr     = 1'b0;
    reg_write    = 1'b0;
    alu_op       = AluAdd;
    sel_alu_a    = 1'b0;
    sel_alu_b    = 2'd0;
    sel_pc       = 1'b0;
    sel_wb       = 2'd0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        sel_alu_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        load_a       = 1'b1;
        load_b       = 1'b1;
        load_alu_out = 1'b1;
        sel_alu_b    = 2'd2;
      end
      StExecR: begin
        sel_alu_a    = 1'b1;
        load_alu_out = 1'b1;
        if (r_legal && funct7 == 7'b0100000) alu_op = AluSub;
      end
      StExecI, StAddrCalc: begin
        sel_alu_a    = 1'b1;
        sel_alu_b    = 2'd2;
        load_alu_out = 1'b1;
      end
      StMemLoad: begin
        mem_read = 1'b1;
        load_mdr = mem_ready;
      end
      StWbLoad: begin
        reg_write = 1'b1;
        sel_wb    = 2'd1;
      end
      StMemStore: mem_write = 1'b1;
      StWbAlu:    reg_write = 1'b1;
      StBranch: begin
        sel_alu_a = 1'b1;
        alu_op    = AluSub;
        sel_pc    = 1'b1;
        // BEQ takes the branch on zero, BNE on not-zero.
        pc_write  = br_legal && (zero ^ (funct3 == 3'b001));
      end
      StJal: begin
        reg_write = 1'b1;
        sel_wb    = 2'd2;
        pc_write  = 1'b1;
        sel_pc    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;
  assign err       = err_q;
  assign err_cause = cause_q;
  assign instret   = instret_q;

endmodule

// File: doc/ctrl_multicycle.md
CTRL_MULTICYCLE -- requirements
Module: ctrl_multicycle

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles per memory access before error; legal range 1..255.
REQ-003 Parameter EN_JAL, default 1: when 0, JAL is treated as an illegal opcode.
REQ-004 Port list, one clock; reset is synchronous and active-high:
  clk  in  1  clock, all state changes on rising edge
  rst  in  1  synchronous active-high reset
  instr  in  32  current instruction-register contents
  zero  in  1  ALU zero flag, combinational
  mem_ready  in  1  memory completes the current access this cycle
  pc_write, ir_write, mem_read, mem_write  out  1 each  datapath enables
  load_a, load_b, load_alu_out, load_mdr, reg_write  out  1 each  register enables
  alu_op  out  3  ALU operation
  sel_alu_a  out  1  0=PC, 1=regA
  sel_alu_b  out  2  0=regB, 1=constant 4, 2=immediate
  sel_pc  out  1  0=ALU result, 1=ALUOut
  sel_wb  out  2  0=ALUOut, 1=MDR, 2=PC
  state_out  out  4  current state encoding
  err  out  1  sticky error flag
  err_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
  instret  out  CNT_W  retired-instruction count

Function
REQ-005 The block SHALL be a Moore-style FSM with states RESET, FETCH, DECODE, EXEC_R, EXEC_I, ADDR_CALC, MEM_LOAD, WB_LOAD, MEM_STORE, WB_ALU, BRANCH, JAL, ERROR.
REQ-006 Every output not listed for a state SHALL be 0 in that state; alu_op SHALL default to ADD; no output SHALL ever be X.
REQ-007 RESET: all enables 0; next state FETCH unconditionally.
REQ-008 FETCH: mem_read=1, sel_alu_a=0, sel_alu_b=1, alu_op=ADD; while mem_ready=0, state holds; in the mem_ready=1 cycle, ir_write=1 and pc_write=1 (sel_pc=0), next state DECODE.
REQ-009 DECODE: load_a=1, load_b=1, load_alu_out=1, sel_alu_a=0, sel_alu_b=2 (branch/JAL target into ALUOut); next state is chosen by instr[6:0]: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->ADDR_CALC, 1100011->BRANCH, 1101111->JAL (EN_JAL=1), any other->ERROR with cause 01.
REQ-010 EXEC_R: sel_alu_a=1, sel_alu_b=0, load_alu_out=1; funct7=0000000 with funct3=000 gives ADD, funct7=0100000 with funct3=000 gives SUB; other encodings go to ERROR (cause 01); otherwise next state WB_ALU.
REQ-011 EXEC_I: sel_alu_a=1, sel_alu_b=2, alu_op=ADD, load_alu_out=1; next state WB_ALU.
REQ-012 WB_ALU: reg_write=1, sel_wb=0; next state FETCH.
REQ-013 ADDR_CALC: sel_alu_a=1, sel_alu_b=2, alu_op=ADD, load_alu_out=1; next state MEM_LOAD for a load opcode, MEM_STORE for a store opcode.
REQ-014 MEM_LOAD: mem_read=1; on mem_ready=1, load_mdr=1 and next state WB_LOAD. WB_LOAD: reg_write=1, sel_wb=1; next state FETCH.
REQ-015 MEM_STORE: mem_write=1, held until mem_ready=1; next state FETCH.
REQ-016 BRANCH: sel_alu_a=1, sel_alu_b=0, alu_op=SUB, sel_pc=1. pc_write SHALL equal zero XOR (instr[14:12]==001), so BEQ uses funct3 000 and BNE uses funct3 001. Other funct3 values go to ERROR (cause 01). Next state FETCH.
REQ-017 JAL: reg_write=1, sel_wb=2, pc_write=1, sel_pc=1; next state FETCH.
REQ-018 Wait timer: counts consecutive cycles in FETCH/MEM_LOAD/MEM_STORE with mem_ready=0 and clears on any state change. When the count reaches MEM_TIMEOUT with mem_ready still 0, next state SHALL be ERROR with cause 10. If mem_ready=1 arrives in that same cycle, it wins and the state advances normally.
REQ-019 ERROR: all enables 0, err=1, err_cause holds the first cause; the state is left only by rst.
REQ-020 instret SHALL increment by 1 on each transition into FETCH from WB_ALU, WB_LOAD, MEM_STORE, BRANCH or JAL, and SHALL wrap modulo 2^CNT_W.

Reset
REQ-021 When rst=1 at a clock edge, from any state including mid-wait or ERROR, the next state SHALL be RESET, with instret=0, wait timer=0, err=0 and err_cause=00.

Structure
REQ-022 Package ctrl_pkg SHALL hold the state enum (4-bit), ALU op constants (ADD=001, SUB=010), the opcode constants and the err_cause constants.
REQ-023 The wait timer SHALL be a separate sub-module, ctrl_wait_timer (inputs: enable, clear, limit; output: expired).

Verification
REQ-024 add x3,x1,x2 with mem_ready tied to 1 -> state sequence FETCH, DECODE, EXEC_R, WB_ALU (4 cycles); alu_op=001 in EXEC_R; reg_write=1 in WB_ALU; instret goes 0->1.
REQ-025 lw with mem_ready low for 3 cycles in MEM_LOAD -> mem_read held 4 cycles; load_mdr=1 only in the ready cycle; WB_LOAD sel_wb=1.
REQ-026 BNE (funct3=001): with zero=0 -> pc_write=1 in BRANCH; with zero=1 -> pc_write=0.
REQ-027 mem_ready held 0 in FETCH with MEM_TIMEOUT=3 -> ERROR after 3 wait cycles, err=1, err_cause=10. A second run with mem_ready=1 on the expiry cycle -> DECODE, no error.
REQ-028 Opcode 1111111 -> ERROR with cause 01; rst pulse -> RESET then FETCH, with err=0 and instret=0.
REQ-029 CNT_W=4, run 17 addi instructions -> instret wraps to 1.
